note_out_bridge: RTL
====================

Name: note_out_bridge

Overview:
- CPU-to-synth write bridge on the same memory-mapped bus used by the bongo input bridge, in the opposite direction: the CPU writes note commands and this block plays them out to the synth voice.
- Commands are queued in a small FIFO.
- A sequencer holds each note on `note_code`/`note_valid` for a programmed duration, then inserts a silent gap.
- A status register reports queue level, busy and overflow back to the CPU.

Parameters:
- FIFO_DEPTH, 4, number of queued commands; power of two, minimum 2.
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); minimum 2.
- GAP_TICKS, 1, silent ticks inserted after each note; 0 means no gap state.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- addr  in  32  byte address; only addr[3:2] decoded, rest ignored
- d_in  in  32  write data
- wr  in  1  write strobe, one transfer per high cycle
- rd  in  1  read strobe
- d_out  out  32  registered read data
- note_code  out  7  note currently played
- note_valid  out  1  high while a note is sounding
- note_vel  out  7  velocity of current note (see Optional Feature)
- busy  out  1  high when not IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0, async): FIFO empty, overflow=0, state IDLE, prescaler=0, every output 0 (`d_out`, `note_code`, `note_valid`, `note_vel`, `busy`).
- Register map, addr[3:2]:
  - 0 NOTE (W): d_in[6:0]=note, d_in[15:8]=duration in ticks, d_in[22:16]=velocity.
  - 1 STATUS (R): bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits[11:8] level; other bits 0.
  - 2 CTRL (W): bit0 flush, bit1 clear overflow; self-clearing, not stored.
  - 3: reserved; reads 0, writes ignored.
- Reads: when rd=1, `d_out` loads the selected register on the next edge and holds until the next rd. Writes to STATUS have no effect. rd and wr in the same cycle are both serviced; the read returns pre-write state.
- NOTE write when FIFO not full: entry pushed, level+1.
- NOTE write when full: entry dropped, overflow sticky set. If a pop occurs in the same cycle, the write is accepted and level is unchanged.
- Sequencer FSM, states IDLE, PLAY, GAP:
  - IDLE: if FIFO non-empty, pop the head.
    - Duration 0: entry discarded; stay IDLE, re-evaluate next cycle.
    - Otherwise: next cycle latch `note_code`/`note_vel`, load remaining=duration, clear prescaler, enter PLAY.
  - PLAY: `note_valid`=1. Prescaler counts 0..TICK_DIV-1; at wrap, remaining−1. When remaining reaches 0, go to GAP (or IDLE if GAP_TICKS=0).
    - `note_valid` is high for exactly duration×TICK_DIV cycles.
  - GAP: `note_valid`=0, `note_code` holds its last value. Lasts GAP_TICKS×TICK_DIV cycles, then IDLE.
- Back-to-back: with GAP_TICKS=0 and a queued entry, PLAY→IDLE→PLAY, giving exactly one cycle with `note_valid`=0 between notes.
- CTRL flush: FIFO emptied. Any PLAY/GAP aborts to IDLE; `note_valid` is 0 from the next cycle and the prescaler clears. A NOTE write in the same cycle as flush is discarded.
- CTRL clear overflow: overflow=0. A simultaneous overflow event wins (stays 1).
- Async reset mid-note: `note_valid` drops immediately with reset assertion; no note resumes after release.
- FIFO pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.

Optional Feature:
- Macro: NOTE_OUT_VELOCITY_EN.
- Defined: d_in[22:16] stored per entry and driven on `note_vel` during PLAY.
- Undefined: velocity bits not stored (narrower FIFO); `note_vel` tied to 7'd0.

Test Plan:
- Bench uses TICK_DIV=4, GAP_TICKS=1, FIFO_DEPTH=4, NOTE_OUT_VELOCITY_EN defined.
- Reset, then write NOTE 0x0003_0245 → `note_valid` high for 8 cycles with `note_code`=0x45, `note_vel`=3; then 4 gap cycles; then busy=0.
- Write 5 NOTEs (duration 0x10) in consecutive cycles while IDLE → first pops, 4 queued, none dropped. Sixth write before any further pop → STATUS reads overflow=1, full=1, level=4.
- Write NOTE duration 0 followed by NOTE 0x0141 → first discarded silently; 0x41 plays for 4 cycles.
- Write CTRL=0x1 during PLAY with 2 queued → `note_valid`=0 next cycle, STATUS level=0, empty=1, busy=0.
- Assert rst low mid-PLAY for 1 cycle → all outputs 0 immediately; STATUS read after release = 0x0000_0004.
- Same cycle: rd of STATUS plus NOTE write into empty FIFO → `d_out` shows empty=1 (pre-write); next read shows busy=1.

Source files
------------

// File: rtl/note_out_bridge.sv
// ---------------------------------------------------------------------------
// note_out_bridge
//
// CPU-to-synth write bridge. The CPU writes note commands over a simple
// memory-mapped bus. The commands queue in a small FIFO. A sequencer holds
// each note on note_code/note_valid for its programmed duration, then
// inserts a silent gap before the next note.
//
// Register map (addr[3:2]):
//   0 NOTE   (W) d_in[6:0] note, d_in[15:8] duration in ticks,
//                d_in[22:16] velocity
//   1 STATUS (R) bit0 busy, bit1 full, bit2 empty, bit3 overflow,
//                bits[11:8] level
//   2 CTRL   (W) bit0 flush, bit1 clear overflow (self-clearing strobes)
//   3 reserved   reads 0, writes ignored
//
// Optional feature macro: NOTE_OUT_VELOCITY_EN
//   defined   : velocity is stored per entry and driven on note_vel
//   undefined : velocity is not stored and note_vel is tied to 0
//
// Parameters:
//   FIFO_DEPTH  queued commands (power of two, >= 2)
//   TICK_DIV    clk cycles per duration tick (>= 2)
//   GAP_TICKS   silent ticks after each note (0 = no gap state)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   addr        byte address (only addr[3:2] decoded)
//   d_in        write data
//   wr, rd      write / read strobes (one transfer per high cycle)
//   d_out       registered read data, held until the next rd
//   note_code   note currently played (held through the gap)
//   note_valid  high while a note is sounding
//   note_vel    velocity of the current note
//   busy        sequencer not idle, or FIFO non-empty
// ---------------------------------------------------------------------------
module note_out_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 50000,
    parameter int GAP_TICKS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    input  logic        wr,
    input  logic        rd,
    output logic [31:0] d_out,
    output logic [6:0]  note_code,
    output logic        note_valid,
    output logic [6:0]  note_vel,
    output logic        busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = PTR_W + 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam bit HAS_GAP = (GAP_TICKS != 0);

`ifdef NOTE_OUT_VELOCITY_EN
    localparam int ENTRY_W = 22;
`else
    localparam int ENTRY_W = 15;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // ---------------- bus decode ----------------
    logic sel_note, sel_ctrl;
    logic flush, clr_ovf, note_wr;

    assign sel_note = (addr[3:2] == 2'd0);
    assign sel_ctrl = (addr[3:2] == 2'd2);
    assign flush    = wr & sel_ctrl & d_in[0];
    assign clr_ovf  = wr & sel_ctrl & d_in[1];
    // A NOTE write coinciding with a flush is thrown away with the queue.
    assign note_wr  = wr & sel_note & ~flush;

    // ---------------- FIFO ----------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;
    logic               ovf_reg;
    logic               full, empty, push, pop, ovf_event;
    logic [ENTRY_W-1:0] head, new_entry;
    logic [6:0]         head_code;
    logic [7:0]         head_dur;
    state_t             state_reg;

    assign full  = (level_reg == LVL_W'(FIFO_DEPTH));
    assign empty = (level_reg == '0);

    // The sequencer pops whenever it is idle and something is queued.
    assign pop   = (state_reg == IDLE) & ~empty & ~flush;
    // A write into a full FIFO still fits if the head leaves this cycle.
    assign push      = note_wr & (~full | pop);
    assign ovf_event = note_wr & full & ~pop;

`ifdef NOTE_OUT_VELOCITY_EN
    assign new_entry = {d_in[22:16], d_in[15:8], d_in[6:0]};
`else
    assign new_entry = {d_in[15:8], d_in[6:0]};
`endif

    // Head is read combinationally so a zero-duration entry can be
    // discarded in the same cycle it is popped.
    assign head      = mem[rd_ptr_reg];
    assign head_code = head[6:0];
    assign head_dur  = head[14:7];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Overflow is sticky; a fresh overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else if (ovf_event) begin
            ovf_reg <= 1'b1;
        end else if (clr_ovf) begin
            ovf_reg <= 1'b0;
        end
    end

    // ---------------- sequencer ----------------
    logic [PRE_W-1:0] presc_reg;
    logic [7:0]       remain_reg;
    logic             tick;
    logic [6:0]       vel_reg;

    assign tick = (presc_reg == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            presc_reg  <= '0;
            remain_reg <= '0;
            note_code  <= '0;
            vel_reg    <= '0;
            note_valid <= 1'b0;
        end else if (flush) begin
            state_reg  <= IDLE;
            presc_reg  <= '0;
            remain_reg <= '0;
            note_valid <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Zero-duration entries are popped and dropped here.
                    if (pop && (head_dur != 8'd0)) begin
                        note_code  <= head_code;
`ifdef NOTE_OUT_VELOCITY_EN
                        vel_reg    <= head[21:15];
`endif
                        remain_reg <= head_dur;
                        presc_reg  <= '0;
                        note_valid <= 1'b1;
                        state_reg  <= PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        presc_reg <= '0;
                        if (remain_reg == 8'd1) begin
                            note_valid <= 1'b0;
                            if (HAS_GAP) begin
                                remain_reg <= 8'(GAP_TICKS);
                                state_reg  <= GAP;
                            end else begin
                                remain_reg <= '0;
                                state_reg  <= IDLE;
                            end
                        end else begin
                            remain_reg <= remain_reg - 8'd1;
                        end
                    end else begin
                        presc_reg <= presc_reg + PRE_W'(1);
                    end
                end
                GAP: begin
                    if (tick) begin
                        presc_reg <= '0;
                        if (remain_reg == 8'd1) begin
                            remain_reg <= '0;
                            state_reg  <= IDLE;
                        end else begin
                            remain_reg <= remain_reg - 8'd1;
                        end
                    end else begin
                        presc_reg <= presc_reg + PRE_W'(1);
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    note_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef NOTE_OUT_VELOCITY_EN
    assign note_vel = vel_reg;
`else
    assign note_vel = 7'd0;
`endif

    assign busy = (state_reg != IDLE) | ~empty;

    // ---------------- read path ----------------
    logic [31:0] status_word;
    logic [3:0]  level_nib;

    assign level_nib = 4'(level_reg);

    always_comb begin
        status_word       = '0;
        status_word[0]    = busy;
        status_word[1]    = full;
        status_word[2]    = empty;
        status_word[3]    = ovf_reg;
        status_word[11:8] = level_nib;
    end

    // Sampled before this edge's writes, so rd+wr returns pre-write state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
        end else if (rd) begin
            d_out <= (addr[3:2] == 2'd1) ? status_word : 32'd0;
        end
    end

    // Bits of the bus that this block never looks at.
`ifdef NOTE_OUT_VELOCITY_EN
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], d_in[31:23], d_in[7]};
`else
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], d_in[31:16], d_in[7], vel_reg};
`endif

endmodule
